// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the pipelined floating-point adder.
//   - Default field widths (FP32) and the word width derived from them.
//   - Flag bit positions inside the 3-bit {invalid, overflow, inexact} vector.
//   - Canonical quiet NaN for the default format.
//   - fp_op_t: unpacked operand {sign, exp, man, is_zero, is_inf, is_nan} in
//     the default format (the adder builds a width-parametrised twin).
//   - make_flags(): assembles a flag vector from its three named bits.
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int DEF_EXP_W = 8;
   localparam int DEF_MAN_W = 23;
   localparam int DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;
   localparam int DEF_BIAS  = (1 << (DEF_EXP_W - 1)) - 1;

   localparam int FLAG_INEXACT  = 0;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_INVALID  = 2;

   // sign 0, exponent all ones, mantissa MSB set, remaining bits clear
   localparam logic [DEF_W-1:0] QNAN_DEF =
      {1'b0, {DEF_EXP_W{1'b1}}, 1'b1, {(DEF_MAN_W-1){1'b0}}};

   typedef struct packed {
      logic                 sign;
      logic [DEF_EXP_W-1:0] exp;
      logic [DEF_MAN_W-1:0] man;
      logic                 is_zero;
      logic                 is_inf;
      logic                 is_nan;
   } fp_op_t;

   function automatic logic [2:0] make_flags(input logic invalid,
                                             input logic overflow,
                                             input logic inexact);
      logic [2:0] f;
      f                = '0;
      f[FLAG_INVALID]  = invalid;
      f[FLAG_OVERFLOW] = overflow;
      f[FLAG_INEXACT]  = inexact;
      return f;
   endfunction

endpackage

// File: rtl/fp_norm_shift.sv
// -----------------------------------------------------------------------------
// fp_norm_shift
// Leading-zero count and normalising left shift for the stage-3 mantissa.
//   mant_in  : WIDTH-bit unnormalised mantissa
//   mant_out : mant_in shifted left so that its MSB is 1 (all zero if input 0)
//   shamt    : number of leading zeros (WIDTH when mant_in is zero)
// Purely combinational.
// -----------------------------------------------------------------------------
module fp_norm_shift #(
   parameter int WIDTH = 27,
   parameter int SHW   = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] mant_in,
   output logic [WIDTH-1:0] mant_out,
   output logic [SHW-1:0]   shamt
);

   logic found;

   always_comb begin
      shamt = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found) begin
            if (mant_in[i]) begin
               found = 1'b1;
            end else begin
               shamt = shamt + SHW'(1);
            end
         end
      end
      mant_out = mant_in << shamt;
   end

endmodule

// File: rtl/fp_add_pipe.sv
// -----------------------------------------------------------------------------
// fp_add_pipe
// Pipelined IEEE-754 style adder/subtractor with valid/ready streaming.
// Build option: define FP_ADD_ROUND_EN for round-to-nearest-even; without it
// the result is truncated toward zero (inexact is reported either way).
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : operand handshake
//   a, b, sub       : operands; sub=1 computes a-b
//   out_valid/ready : result handshake
//   result, flags   : sum/difference and {invalid, overflow, inexact}
//
// Handshake: a beat moves on a rising edge when valid && ready are both high.
// in_ready = !(out_valid && !out_ready); while the output is held every stage
// register freezes, otherwise all stages advance together (empty stages are
// plain bubbles), so output accept and input accept can share a cycle.
//
// Pipeline: operand register (s0) -> align (s1) -> add (s2) -> normalise /
// round into the output register. Accept on edge N, out_valid after N+3.
// Inputs with exponent 0 are flushed to signed zero; results that would be
// subnormal flush to signed zero with inexact set.
// -----------------------------------------------------------------------------
module fp_add_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = DEF_EXP_W,
   parameter int MAN_W = DEF_MAN_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic [2:0]           flags
);

   localparam int W      = 1 + EXP_W + MAN_W;
   localparam int XW     = MAN_W + 4;          // hidden + mantissa + G/R/S
   localparam int SW     = MAN_W + 5;          // XW plus carry
   localparam int SHW    = $clog2(XW + 1);
   localparam int EW     = ((EXP_W > SHW) ? EXP_W : SHW) + 2;  // msb = negative
   localparam int SH_CAP = MAN_W + 3;          // beyond this B is all sticky

   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
   localparam logic [EW-1:0]    EXP_INF  = EW'((1 << EXP_W) - 1);

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
      logic             is_zero;
      logic             is_inf;
      logic             is_nan;
   } op_t;

   function automatic op_t unpack(input logic [W-1:0] w, input logic flip);
      op_t o;
      o.sign    = w[W-1] ^ flip;
      o.exp     = w[W-2 -: EXP_W];
      o.is_zero = (o.exp == '0);
      o.man     = o.is_zero ? '0 : w[MAN_W-1:0];
      o.is_inf  = (o.exp == EXP_ONES) && (w[MAN_W-1:0] == '0);
      o.is_nan  = (o.exp == EXP_ONES) && (w[MAN_W-1:0] != '0);
      return o;
   endfunction

   logic adv;
   assign adv      = !(out_valid && !out_ready);
   assign in_ready = adv;

   // ---------------- stage 0: operand register ----------------
   logic         s0_valid;
   logic [W-1:0] s0_a, s0_b;
   logic         s0_sub;

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid <= 1'b0;
      end else if (adv) begin
         s0_valid <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (adv && in_valid) begin
         s0_a   <= a;
         s0_b   <= b;
         s0_sub <= sub;
      end
   end

   // ---------------- stage 1: specials, swap, align ----------------
   op_t              op_a, op_b, op_l, op_s;
   logic             a_big;
   logic [EXP_W-1:0] exp_d;
   logic [31:0]      sh_amt;
   logic [XW-1:0]    xl, xs, xs_sh, lost_mask, xs_al;
   logic             sp_c, sp_nan, sp_invalid;
   logic [W-1:0]     sp_res;

   always_comb begin
      op_a  = unpack(s0_a, 1'b0);
      op_b  = unpack(s0_b, s0_sub);
      a_big = {op_a.exp, op_a.man} >= {op_b.exp, op_b.man};
      op_l  = a_big ? op_a : op_b;
      op_s  = a_big ? op_b : op_a;
      exp_d = op_l.exp - op_s.exp;
      sh_amt = (32'(exp_d) > 32'(SH_CAP)) ? 32'(SH_CAP) : 32'(exp_d);
      xl     = {!op_l.is_zero, op_l.man, 3'b000};
      xs     = {!op_s.is_zero, op_s.man, 3'b000};
      xs_sh  = xs >> sh_amt;
      // everything pushed below the sticky slot folds into it
      lost_mask = ~({XW{1'b1}} << sh_amt);
      xs_al     = {xs_sh[XW-1:1], xs_sh[0] | (|(xs & lost_mask))};

      sp_invalid = op_a.is_inf && op_b.is_inf && (op_a.sign != op_b.sign);
      sp_nan     = op_a.is_nan || op_b.is_nan || sp_invalid;
      sp_c       = sp_nan || op_a.is_inf || op_b.is_inf;
      if (sp_nan) begin
         sp_res = QNAN;
      end else if (op_a.is_inf) begin
         sp_res = {op_a.sign, EXP_ONES, {MAN_W{1'b0}}};
      end else begin
         sp_res = {op_b.sign, EXP_ONES, {MAN_W{1'b0}}};
      end
   end

   logic             s1_valid, s1_special, s1_invalid, s1_sign, s1_eff_sub;
   logic [W-1:0]     s1_sp_res;
   logic [EXP_W-1:0] s1_exp;
   logic [XW-1:0]    s1_xl, s1_xs;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (adv) begin
         s1_valid <= s0_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (adv && s0_valid) begin
         s1_special <= sp_c;
         s1_invalid <= sp_invalid;
         s1_sp_res  <= sp_res;
         s1_sign    <= op_l.sign;
         s1_eff_sub <= op_a.sign ^ op_b.sign;
         s1_exp     <= op_l.exp;
         s1_xl      <= xl;
         s1_xs      <= xs_al;
      end
   end

   // ---------------- stage 2: add / subtract magnitudes ----------------
   // The swap guarantees xl >= xs, so the difference never goes negative.
   logic [SW-1:0] sum_c;

   always_comb begin
      if (s1_eff_sub) begin
         sum_c = {1'b0, s1_xl} - {1'b0, s1_xs};
      end else begin
         sum_c = {1'b0, s1_xl} + {1'b0, s1_xs};
      end
   end

   logic             s2_valid, s2_special, s2_invalid, s2_sign, s2_eff_sub;
   logic [W-1:0]     s2_sp_res;
   logic [EXP_W-1:0] s2_exp;
   logic [SW-1:0]    s2_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
      end else if (adv) begin
         s2_valid <= s1_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (adv && s1_valid) begin
         s2_special <= s1_special;
         s2_invalid <= s1_invalid;
         s2_sp_res  <= s1_sp_res;
         s2_sign    <= s1_sign;
         s2_eff_sub <= s1_eff_sub;
         s2_exp     <= s1_exp;
         s2_sum     <= sum_c;
      end
   end

   // ---------------- stage 3: normalise, round, pack ----------------
   logic [XW-1:0]    ns_mant;
   logic [SHW-1:0]   ns_lz;

   fp_norm_shift #(.WIDTH(XW), .SHW(SHW)) u_norm (
      .mant_in  (s2_sum[XW-1:0]),
      .mant_out (ns_mant),
      .shamt    (ns_lz)
   );

   logic [XW-1:0]    n_mant;
   logic [EW-1:0]    e_norm, e_fin;
   logic             rnd_inc, inexact;
   logic [MAN_W+1:0] mr;
   logic [MAN_W-1:0] man_out;
   logic [W-1:0]     res_c;
   logic [2:0]       flags_c;

   always_comb begin
      if (s2_sum[SW-1]) begin
         // carry out: shift right once, the dropped bit joins sticky
         n_mant = {s2_sum[SW-1:2], s2_sum[1] | s2_sum[0]};
         e_norm = EW'(s2_exp) + EW'(1);
      end else begin
         n_mant = ns_mant;
         e_norm = EW'(s2_exp) - EW'(ns_lz);
      end
      inexact = |n_mant[2:0];
`ifdef FP_ADD_ROUND_EN
      rnd_inc = n_mant[2] & (n_mant[1] | n_mant[0] | n_mant[3]);
`else
      rnd_inc = 1'b0;
`endif
      mr      = {1'b0, n_mant[XW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
      // rounding carry leaves 10.00..0: renormalise by one position
      e_fin   = e_norm + EW'(mr[MAN_W+1]);
      man_out = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];

      if (s2_special) begin
         res_c   = s2_sp_res;
         flags_c = make_flags(s2_invalid, 1'b0, 1'b0);
      end else if (s2_sum == '0) begin
         // exact zero: opposite-signed cancellation gives +0
         res_c   = {s2_eff_sub ? 1'b0 : s2_sign, {(W-1){1'b0}}};
         flags_c = '0;
      end else if (e_fin[EW-1] || (e_fin == '0)) begin
         res_c   = {s2_sign, {(W-1){1'b0}}};
         flags_c = make_flags(1'b0, 1'b0, 1'b1);
      end else if (e_fin >= EXP_INF) begin
         res_c   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
         flags_c = make_flags(1'b0, 1'b1, 1'b1);
      end else begin
         res_c   = {s2_sign, e_fin[EXP_W-1:0], man_out};
         flags_c = make_flags(1'b0, 1'b0, inexact);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
      end else if (adv) begin
         out_valid <= s2_valid;
         if (s2_valid) begin
            result <= res_c;
            flags  <= flags_c;
         end
      end
   end

endmodule

// File: tb/tb_fp_add_pipe.sv
module tb_fp_add_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a, b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [2:0]  flags;

   int tests = 0;
   int fails = 0;

   logic [34:0] exp_q[$];
   logic        stalled = 1'b0;
   logic [34:0] held;

   fp_add_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- check helper ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) check("stable_while_stalled", {29'd0, result, flags}, {29'd0, held});
         if (out_valid && out_ready) begin
            tests++;
            assert (exp_q.size() != 0) else begin
               fails++;
               $error("FAIL unexpected_out: observed %0h expected none", {result, flags});
            end
            if (exp_q.size() != 0) check("out", {29'd0, result, flags}, {29'd0, exp_q.pop_front()});
         end
         stalled = out_valid && !out_ready;
         held    = {result, flags};
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
   task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                       input logic [31:0] er, input logic [2:0] ef);
      logic acc;
      a        = ta;
      b        = tb;
      sub      = ts;
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int n = 0; n < 100 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      check("accept", 64'(acc), 64'(1));
      if (acc) exp_q.push_back({er, ef});
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
   endtask

   task automatic check_latency(input string tag);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("%s_latency_edge%0d", tag, i), 64'(out_valid), 64'(i == 3));
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] int2fp(input int unsigned n);
      int          p;
      logic [31:0] m;
      if (n == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 32; i++) if (n[i]) p = i;
      m = n << (23 - p);
      return {1'b0, 8'(127 + p), m[22:0]};
   endfunction

   logic [31:0] bp_a [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40A00000, 32'h40C00000};
   logic [31:0] bp_r [6] = '{32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000};

   // ---------------- directed sequence ----------------
   initial begin
      int unsigned x, y;
      int          s;
      logic [31:0] er;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_in_ready",  64'(in_ready),  64'(1));
      check("reset_result",    64'(result),    64'(0));
      check("reset_flags",     64'(flags),     64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // basic add with latency
      send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
      idle();
      check_latency("basic");
      drain("basic");

      // directed values, back-to-back
      send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
      send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
      send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
      send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
      send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
`ifdef FP_ADD_ROUND_EN
      send(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001);
`else
      send(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 3'b001);
`endif
      send(32'h40000000, 32'hC0400000, 1'b0, 32'hBF800000, 3'b000);
      send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000);
      send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b000);
      send(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
      send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
      send(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);
      send(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b001);
      send(32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 3'b000);
      idle();
      drain("directed");

      // random small integers: sums and differences are exact
      for (int i = 0; i < 10; i++) begin
         x = $urandom_range(1, 1000);
         y = $urandom_range(1, 1000);
         s = $urandom_range(0, 1);
         if (s == 0)      er = int2fp(x + y);
         else if (x > y)  er = int2fp(x - y);
         else if (x < y)  er = {1'b1, int2fp(y - x)} | 32'h80000000;
         else             er = 32'h0;
         send(int2fp(x), int2fp(y), s[0], er, 3'b000);
      end
      idle();
      drain("random");

      // back-pressure: 6 back-to-back pairs, out_ready low for 5 cycles
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(bp_a[i], 32'h3F800000, 1'b0, bp_r[i], 3'b000);
            idle();
         end
         begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("bp_out_valid_full", 64'(out_valid), 64'(1));
            check("bp_in_ready_low",   64'(in_ready),  64'(0));
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain("backpressure");

      // reset with three operations in flight
      send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
      send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000);
      send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 3'b000);
      idle();
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_in_ready",  64'(in_ready),  64'(1));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("midrst_quiet%0d", i), 64'(out_valid), 64'(0));
      end
      @(posedge clk);
      #1;
      send(32'h40800000, 32'h40000000, 1'b0, 32'h40C00000, 3'b000);
      idle();
      check_latency("after_reset");
      drain("after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, pipelined IEEE-754 floating-point adder/subtractor with valid/ready handshake, the streaming successor to the single-cycle combinational float adder in the FPU.
- Generalised over exponent and mantissa width.
- Handles specials (NaN, Inf, signed zero), optional round-to-nearest-even, exception flags and back-pressure.
- Sits between the FPU operand-issue stage and the result writeback/arbiter.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored mantissa field width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept this cycle
- a  in  W  operand A
- b  in  W  operand B
- sub  in  1  1: compute a−b (B sign inverted before the add), 0: a+b
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  W  sum/difference
- flags  out  3  {invalid, overflow, inexact}, qualified by out_valid

## Operation
- Inputs with exponent 0 are treated as signed zero (flush-to-zero on input).
- Outputs never subnormal: a normalised exponent ≤0 becomes signed zero with inexact=1.
- Special cases, resolved in stage 1 and carried as a bypass result:
  - Any NaN → canonical qNaN: sign 0, exponent all-ones, mantissa MSB 1, rest 0.
  - Inf + (−Inf) after the sub inversion → qNaN, invalid=1.
  - Inf ± finite → that Inf.
  - Zero results: exact x+(−x) → +0; (−0)+(−0) → −0.
- Stage 1 (align):
  - Swap so |A| ≥ |B| by comparing {exp,man}.
  - Exponent difference d = expA−expB.
  - Shift B's hidden-bit mantissa right by min(d, MAN_W+3).
  - Keep guard, round and sticky bits; sticky = OR of all bits shifted past round.
- Stage 2 (add): effective op = signA XOR signB'.
  - Add: MAN_W+5-bit sum including the carry.
  - Subtract: magnitude difference, never negative because of the swap.
  - Result sign = sign of the larger operand.
- Stage 3 (normalise/round):
  - On carry, shift right 1 and increment the exponent, folding the shifted-out bit into sticky.
  - Otherwise, leading-zero count and shift left, decrementing the exponent.
  - Round per configuration; a rounding carry renormalises (exponent +1).
  - Exponent ≥ 2^EXP_W−1 → ±Inf with overflow=1 and inexact=1.
  - inexact = any nonzero guard/round/sticky bit after normalisation.

## Timing
- Latency: 3 cycles. A pair accepted on edge N gives out_valid=1 after edge N+3.
- Throughput: 1 result per cycle when out_ready=1.
- in_ready = !(out_valid && !out_ready), combinational. A transfer occurs when in_valid && in_ready.
- Stall:
  - While out_valid && !out_ready, every stage register and valid bit holds.
  - result and flags stay stable until accepted.
- Bubbles: stage valid bits propagate independently. An empty stage never blocks upstream when the output is not stalled.
- Reset: all valid bits, result and flags clear to 0, so out_valid=0 and in_ready=1 in the first cycle after reset.
  - Reset mid-operation discards in-flight operations; none emerge afterwards.
- Simultaneous output accept and input accept in the same cycle is legal and does not create a bubble.

## Configuration
- FP_ADD_ROUND_EN defined:
  - Round-to-nearest, ties-to-even from guard/round/sticky.
  - inexact set as described above.
- FP_ADD_ROUND_EN undefined:
  - Truncation toward zero; guard/round/sticky discarded after normalisation.
  - inexact still reported.
  - Overflow saturates to ±Inf.
- Latency and handshake are identical in both builds.

## Structure
- Package fp_pkg holds:
  - field-width localparams derived from EXP_W/MAN_W;
  - a struct type for the unpacked operand {sign, exp, man, is_zero, is_inf, is_nan};
  - the canonical qNaN constant;
  - the flag bit indices.
- Sub-module fp_norm_shift: leading-zero count plus left shift of the stage-3 mantissa, parametrised by width, returning the shifted mantissa and shift amount.

## Test plan
- Basic add, FP32 defaults: a=0x3F800000 + b=0x3F800000 → result=0x40000000, flags=000, out_valid exactly 3 cycles after accept.
- Exact cancellation: a=0x3F800000, b=0x3F800000, sub=1 → 0x00000000 (+0). −0 + −0 → 0x80000000.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
- Rounding with FP_ADD_ROUND_EN:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000, inexact=1.
  - 0x3F800000 + 0x33C00000 → 0x3F800001.
  - Without the macro, both → 0x3F800000.
- Back-pressure: stream 6 back-to-back pairs while holding out_ready=0 for 5 cycles.
  - in_ready drops once stage 3 is full.
  - All 6 results emerge in order with none lost or duplicated.
  - result stays stable while stalled.
- Reset mid-stream: assert rst for 1 cycle with 3 operations in flight → out_valid=0 next cycle, none of the 3 ever appear, and a new pair completes after 3 cycles.
